// File: rtl/spi_cmd_pkg.sv
// Shared constants for the SPI command engine: opcodes, sync/ack bytes
// and FSM state encoding.
package spi_cmd_pkg;

   localparam logic [7:0] OP_NOP    = 8'h00;
   localparam logic [7:0] OP_INIT   = 8'h11;
   localparam logic [7:0] OP_WR_INV = 8'h02;
   localparam logic [7:0] OP_WR_LED = 8'h04;
   localparam logic [7:0] OP_WR_VEC = 8'h06;
   localparam logic [7:0] OP_RD_VEC = 8'h07;

   localparam logic [7:0] INIT_BYTE = 8'h11;
   localparam logic [7:0] ACK_BYTE  = 8'h40;

   typedef enum logic {
      ST_SYNC  = 1'b0,
      ST_FRAME = 1'b1
   } state_t;

endpackage

// File: rtl/spi_cmd_vec_ram.sv
// Byte-wide vector store: one synchronous write port and one
// asynchronous read port sharing a single address; contents not reset.
module spi_cmd_vec_ram #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [7:0]    i_wdata,
   output logic [7:0]    o_rdata
);

   logic [7:0] r_mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/spi_cmd_engine.sv
// Frames the SPI slave byte stream into fixed-length commands and answers
// every byte. Optional mid-frame abort timer: SPI_CMD_TIMEOUT_EN.
module spi_cmd_engine
   import spi_cmd_pkg::*;
#(
   parameter int FRAME_BYTES = 8,
   parameter int VEC_DEPTH   = 16,
   parameter int LED_W       = 3
`ifdef SPI_CMD_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = 1000000
`endif
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   output logic             rx_ready,
   output logic             tx_valid,
   output logic [7:0]       tx_data,
   input  logic             tx_ready,
   output logic [LED_W-1:0] led,
   output logic             synced,
   output logic             frame_done,
   output logic             frame_err
);

   localparam int IW = $clog2(FRAME_BYTES);
   localparam int PW = $clog2(VEC_DEPTH);

   state_t           r_state, w_state_n;
   logic [IW-1:0]    r_idx, w_idx_n;
   logic [7:0]       r_op, w_op_n;
   logic [LED_W-1:0] r_b1, w_b1_n;
   logic [LED_W-1:0] r_led, w_led_n;
   logic [PW-1:0]    r_ptr, w_ptr_n;
   logic             r_txv, w_txv_n;
   logic [7:0]       r_txd, w_txd_n;
   logic             r_done, w_done_n;

   logic             w_accept, w_rx_ready, w_last, w_body;
   logic             w_resp_v, w_we;
   logic [7:0]       w_resp, w_rdata;

   // One-entry response buffer: a byte may drain and refill in one cycle.
   assign w_rx_ready = ~r_txv | tx_ready;
   assign w_accept   = rx_valid & w_rx_ready;
   assign w_last     = (r_idx == IW'(FRAME_BYTES - 1));
   assign w_body     = (r_idx >= IW'(1)) && (r_idx <= IW'(4));

   spi_cmd_vec_ram #(
      .DEPTH (VEC_DEPTH)
   ) u_ram (
      .CLK     (CLK),
      .i_we    (w_we),
      .i_addr  (r_ptr),
      .i_wdata (rx_data),
      .o_rdata (w_rdata)
   );

`ifdef SPI_CMD_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] r_cnt;
   logic          r_ferr;
   logic          w_to_hit;

   assign w_to_hit = (r_idx != '0) && !w_accept
                   && (r_cnt == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_cnt  <= '0;
         r_ferr <= 1'b0;
      end else begin
         r_ferr <= w_to_hit;
         if (w_accept || w_to_hit || r_idx == '0) r_cnt <= '0;
         else r_cnt <= r_cnt + CW'(1);
      end
   end

   assign frame_err = r_ferr;
`else
   assign frame_err = 1'b0;
`endif

   always_comb begin
      w_state_n = r_state;
      w_idx_n   = r_idx;
      w_op_n    = r_op;
      w_b1_n    = r_b1;
      w_led_n   = r_led;
      w_ptr_n   = r_ptr;
      w_done_n  = 1'b0;
      w_resp_v  = 1'b0;
      w_resp    = 8'h00;
      w_we      = 1'b0;
      if (w_accept) begin
         unique case (r_state)
            ST_SYNC: begin
               if (rx_data == INIT_BYTE) begin
                  w_state_n = ST_FRAME;
                  w_idx_n   = '0;
                  w_resp_v  = 1'b1;
                  w_resp    = ACK_BYTE;
               end
            end
            ST_FRAME: begin
               w_resp_v = 1'b1;
               w_done_n = w_last;
               w_idx_n  = w_last ? '0 : r_idx + IW'(1);
               if (r_idx == '0) begin
                  w_op_n = rx_data;
                  w_resp = rx_data;
               end else begin
                  if (r_idx == IW'(1)) w_b1_n = rx_data[LED_W-1:0];
                  unique case (1'b1)
                     (r_op == OP_WR_INV): w_resp = ~rx_data;
                     (r_op == OP_WR_LED): begin
                        w_resp = rx_data;
                        if (w_last) w_led_n = r_b1;
                     end
                     (r_op == OP_WR_VEC): begin
                        if (w_body) begin
                           w_we    = 1'b1;
                           w_ptr_n = r_ptr + PW'(1);
                        end
                     end
                     (r_op == OP_RD_VEC): begin
                        if (w_body) begin
                           w_resp  = w_rdata;
                           w_ptr_n = r_ptr + PW'(1);
                        end
                     end
                     default: w_resp = 8'h00;
                  endcase
               end
            end
            default: w_state_n = ST_SYNC;
         endcase
      end
`ifdef SPI_CMD_TIMEOUT_EN
      if (w_to_hit) begin
         w_idx_n = '0;
         w_op_n  = OP_NOP;
      end
`endif
      w_txd_n = r_txd;
      w_txv_n = r_txv & ~tx_ready;
      if (w_resp_v) begin
         w_txv_n = 1'b1;
         w_txd_n = w_resp;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= ST_SYNC;
         r_idx   <= '0;
         r_op    <= OP_NOP;
         r_b1    <= '0;
         r_led   <= '0;
         r_ptr   <= '0;
         r_txv   <= 1'b0;
         r_txd   <= 8'h00;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_idx   <= w_idx_n;
         r_op    <= w_op_n;
         r_b1    <= w_b1_n;
         r_led   <= w_led_n;
         r_ptr   <= w_ptr_n;
         r_txv   <= w_txv_n;
         r_txd   <= w_txd_n;
         r_done  <= w_done_n;
      end
   end

   assign rx_ready   = w_rx_ready;
   assign tx_valid   = r_txv;
   assign tx_data    = r_txd;
   assign led        = r_led;
   assign synced     = (r_state == ST_FRAME);
   assign frame_done = r_done;

endmodule

// File: tb/tb_spi_cmd_engine.sv
// Directed bench for spi_cmd_engine: sync, LED, invert, vector store,
// backpressure and reset; timeout abort when SPI_CMD_TIMEOUT_EN is set.
module tb_spi_cmd_engine;

   logic       CLK = 1'b0;
   logic       RST;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic [2:0] led;
   logic       synced;
   logic       frame_done;
   logic       frame_err;

   int total = 0;
   int bad   = 0;

   spi_cmd_engine #(
      .FRAME_BYTES (8),
      .VEC_DEPTH   (16),
      .LED_W       (3)
`ifdef SPI_CMD_TIMEOUT_EN
      , .TIMEOUT_CYC (50)
`endif
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .led        (led),
      .synced     (synced),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input string tag, input logic [7:0] b,
                       input logic ev, input logic [7:0] ed,
                       input bit cd = 1'b1);
      @(negedge CLK);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge CLK);
      rx_valid = 1'b0;
      chk({tag, "_v"}, 32'(tx_valid), 32'(ev));
      if (ev && cd) chk({tag, "_d"}, 32'(tx_data), 32'(ed));
   endtask

   task automatic frame(input string tag, input logic [7:0] b[8],
                        input logic [7:0] e[8], input bit cd = 1'b1);
      for (int i = 0; i < 8; i++) begin
         xfer($sformatf("%s%0d", tag, i), b[i], 1'b1, e[i], cd);
         chk($sformatf("%s%0d_fd", tag, i), 32'(frame_done),
             32'(i == 7));
      end
   endtask

   initial begin
      RST      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tx_ready = 1'b1;
      repeat (2) @(negedge CLK);
      chk("rst_led",  32'(led), 32'h0);
      chk("rst_sync", 32'(synced), 32'h0);
      chk("rst_txv",  32'(tx_valid), 32'h0);
      chk("rst_txd",  32'(tx_data), 32'h0);
      chk("rst_fd",   32'(frame_done), 32'h0);
      chk("rst_fe",   32'(frame_err), 32'h0);
      RST = 1'b0;

      xfer("junk", 8'h55, 1'b0, 8'h00);
      chk("junk_sync", 32'(synced), 32'h0);
      xfer("init", 8'h11, 1'b1, 8'h40);
      chk("init_sync", 32'(synced), 32'h1);

      frame("led", '{8'h04, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   '{8'h04, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      chk("led_val", 32'(led), 32'h5);

      frame("inv", '{8'h02, 8'hA5, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   '{8'h02, 8'h5A, 8'hF0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
      chk("inv_led", 32'(led), 32'h5);

      frame("wv", '{8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00},
                  '{8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      for (int f = 0; f < 3; f++)
         frame($sformatf("rvw%0d_", f),
               '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               1'b0);
      frame("rv", '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  '{8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00});

      // backpressure: first byte accepted, second held off for 10 cycles
      @(negedge CLK);
      tx_ready = 1'b0;
      rx_valid = 1'b1;
      rx_data  = 8'h04;
      @(negedge CLK);
      chk("st0_v", 32'(tx_valid), 32'h1);
      chk("st0_d", 32'(tx_data), 32'h04);
      rx_data = 8'h03;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         chk($sformatf("st_rdy%0d", i), 32'(rx_ready), 32'h0);
         chk($sformatf("st_d%0d", i), 32'(tx_data), 32'h04);
      end
      tx_ready = 1'b1;
      @(negedge CLK);
      rx_valid = 1'b0;
      chk("st1_v", 32'(tx_valid), 32'h1);
      chk("st1_d", 32'(tx_data), 32'h03);
      xfer("st2", 8'h00, 1'b1, 8'h00);

      // reset at idx3 with a response byte still pending
      tx_ready = 1'b0;
      #1 RST = 1'b1;
      #1;
      chk("mr_led",  32'(led), 32'h0);
      chk("mr_sync", 32'(synced), 32'h0);
      chk("mr_txv",  32'(tx_valid), 32'h0);
      @(negedge CLK);
      RST      = 1'b0;
      tx_ready = 1'b1;
      xfer("mr_junk", 8'h04, 1'b0, 8'h00);
      xfer("mr_init", 8'h11, 1'b1, 8'h40);
      frame("led2", '{8'h04, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    '{8'h04, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      chk("led2_val", 32'(led), 32'h6);
      frame("rv2", '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   '{8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00});
      frame("unk", '{8'h11, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   '{8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      chk("unk_led", 32'(led), 32'h6);
      chk("unk_sync", 32'(synced), 32'h1);

`ifdef SPI_CMD_TIMEOUT_EN
      xfer("to0", 8'h04, 1'b1, 8'h04);
      xfer("to1", 8'h07, 1'b1, 8'h07);
      for (int i = 0; i < 49; i++) begin
         @(negedge CLK);
         chk($sformatf("to_wait%0d", i), 32'(frame_err), 32'h0);
      end
      @(negedge CLK);
      chk("to_err", 32'(frame_err), 32'h1);
      @(negedge CLK);
      chk("to_pulse", 32'(frame_err), 32'h0);
      chk("to_sync", 32'(synced), 32'h1);
      chk("to_led", 32'(led), 32'h6);
      frame("led3", '{8'h04, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    '{8'h04, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      chk("led3_val", 32'(led), 32'h2);
`else
      repeat (60) @(negedge CLK);
      chk("nofe", 32'(frame_err), 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
